uart_rx_control: RTL and testbench
==================================

# uart_rx_control

Serial receive engine for the UART PHY: it recovers frames from the `rx` line and is the receiving counterpart of the transmit control FSM on the far end of the link. It oversamples the line at 16x the baud rate and validates the start bit. It shifts in 5–9 data bits LSB-first, optionally checks parity, and checks the stop bit. The word is presented upstream with a valid/ready handshake, together with error flags.

## Interface
- `OVERSAMPLE`, default 16: ticks of `baud_x16` per bit; must be a power of two, ≥8.
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  reset, synchronous and active-high.
- `baud_x16`  in  1  one-cycle enable strobe at `OVERSAMPLE` × baud, from the shared baud generator.
- `control`  in  `control_t`  frame format: `num_bits[2:0]`, `parity_en`, `parity_odd`, `stop2`.
- `rx`  in  1  asynchronous serial line; idles high.
- `data`  out  9  received word, right-aligned; unused MSBs are 0.
- `vld`  out  1  `data`, `parity_err` and `frame_err` are valid.
- `rdy`  in  1  the consumer accepts the word.
- `parity_err`  out  1  parity mismatch for the presented word.
- `frame_err`  out  1  stop bit sampled low for the presented word.
- `overrun`  out  1  one-cycle pulse: a completed frame was dropped.
- `busy`  out  1  high in every state except IDLE.

## Operation
- `rx` passes through a 2-flop synchroniser, giving `rx_s`. Falling edge = previous `rx_s`=1 and current `rx_s`=0.
- `num_bits` encoding: 0..4 → 5..9 bits; 5..7 → 8 bits. `stop2` is ignored; a second stop bit is treated as idle.
- `control` is latched on start-edge detection. Changes mid-frame have no effect.
- Tick counter `tcnt` is 4 bits for the default `OVERSAMPLE`. It increments only on `baud_x16` and is cleared on every state change.
- **IDLE**: on a falling edge, go to START.
- **START**: at `tcnt`=OVERSAMPLE/2−1, sample `rx_s`.
  - Sample 0: go to DATA.
  - Sample 1: false start, return to IDLE; no output, no flags.
- **DATA**: sample every OVERSAMPLE ticks, which lands at mid-bit. Shift LSB-first into the shift register; bit counter `bcnt` counts up.
  - After the last bit: go to PARITY if `parity_en`, else STOP.
- **PARITY**: sample one bit. Expected value = XOR of the data bits, XOR `parity_odd`. Go to STOP.
- **STOP**: sample one bit.
  - If `vld` is already high: assert `overrun` for 1 cycle and drop the new word. The held word is unchanged.
  - Else: load `data`, `parity_err` and `frame_err` (`frame_err` = sample==0) and set `vld`.
  - Sample 1: go to IDLE. Sample 0: go to WAIT_IDLE.
- **WAIT_IDLE**: stay until `rx_s`=1, then go to IDLE. This covers breaks and a line held low.
- Handshake: `vld` holds, and `data`/flags stay stable, until a cycle where `vld`&&`rdy`. `vld` deasserts the next cycle. A new word can be loaded in the same cycle as an accept; the accept takes precedence, so there is no overrun.
- Reset values:
  - State = WAIT_IDLE, so a line held low at reset produces no frame.
  - `data`=0, `vld`=0, `parity_err`=0, `frame_err`=0, `overrun`=0, `busy`=1 (WAIT_IDLE).
  - Synchroniser flops = 1.
- Reset mid-frame aborts the frame and drops the held word.

## Timing
- `rx` to `rx_s`: 2 `clk` cycles.
- Start sample: OVERSAMPLE/2 ticks after the edge. Each later sample: OVERSAMPLE ticks after the previous one.
- `vld` rises 1 `clk` after the `baud_x16` cycle that samples the stop bit.
- `overrun` is high for exactly 1 `clk`, in that same cycle position.
- `rdy` is not required for progress: reception continues regardless of the consumer.
- `baud_x16` must have a period of at least 2 `clk` cycles; a continuously high strobe is allowed only in simulation.

## Configuration
- `UART_RX_PARITY_EN` defined: PARITY compares the sampled bit against the expected value and drives `parity_err`.
- `UART_RX_PARITY_EN` undefined:
  - The parity bit is still sampled and skipped, so framing stays correct.
  - `parity_err` is tied 0 and the parity XOR logic is removed.

## Structure
- Shared package `uart_pkg`: `control_t` (common with TX), the `num_bits` decode function, and the `rx_state_t` enum (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE).
- Sub-module `uart_rx_sync`: 2-flop synchroniser with reset value 1, plus falling-edge detect output.

## Test plan
- 8N1, 0xA5, `rdy`=1: `vld` for 1 cycle with `data`=0x0A5; `parity_err`=0, `frame_err`=0.
- 9 bits, even parity, 0x1FF, parity bit driven wrong: `data`=0x1FF, `parity_err`=1. With the macro undefined: `parity_err`=0.
- Low glitch of 5 ticks on idle line: no `vld`; state returns to IDLE; `busy` low again within 2 `clk` after the START sample.
- Stop bit low (0x00 followed by break): `frame_err`=1; no new frame until `rx` returns high; then 0x55 is received correctly.
- `rdy`=0, send 0x11 then 0x22: `data` stays 0x11; `overrun` pulses once at the second stop sample. Raise `rdy`: 0x11 accepted, `vld` drops.
- Assert `reset` during DATA bit 3, then send 0x3C: no partial word is output; 0x3C is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types: frame control word, receive FSM states and
//               the data-bit-count decode.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef struct packed {
        logic [2:0] num_bits;
        logic       parity_en;
        logic       parity_odd;
        logic       stop2;
    } control_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } rx_state_t;

    localparam int unsigned C_MAX_BITS = 9;

    // Codes 0..4 select 5..9 data bits; the unused codes fall back to 8.
    function automatic logic [3:0] decode_num_bits(input logic [2:0] num_bits);
        logic [3:0] w_n;
        if (num_bits <= 3'd4) begin
            w_n = {1'b0, num_bits} + 4'd5;
        end else begin
            w_n = 4'd8;
        end
        return w_n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sync
// Description : Two-flop synchroniser for the rx line (resets to idle-high)
//               with a falling-edge detect on the synchronised output.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic rx_s,
    output logic rx_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= rx;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign rx_s    = r_sync;
    assign rx_fall = r_prev & ~r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx_control.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_control
// Description : UART receive engine: oversampled start validation, 5-9 data
//               bits LSB-first, optional parity, stop check, valid/ready out.
//               Define UART_RX_PARITY_EN to enable the parity comparison.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_control
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       baud_x16,
    input  control_t   control,
    input  logic       rx,
    output logic [8:0] data,
    output logic       vld,
    input  logic       rdy,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned      C_TW   = $clog2(OVERSAMPLE);
    localparam logic [C_TW-1:0]  C_HALF = C_TW'(OVERSAMPLE / 2 - 1);
    localparam logic [C_TW-1:0]  C_FULL = C_TW'(OVERSAMPLE - 1);

    rx_state_t       r_state;
    rx_state_t       w_next;
    logic [C_TW-1:0] r_tcnt;
    logic [3:0]      r_bcnt;
    logic [8:0]      r_shift;
    control_t        r_ctrl;
    logic [8:0]      r_data;
    logic            r_vld;
    logic            r_perr;
    logic            r_ferr;
    logic            r_ovr;

    logic            w_rx_s;
    logic            w_rx_fall;
    logic [3:0]      w_nbits;
    logic            w_start_tick;
    logic            w_bit_tick;
    logic            w_load;
    logic            w_drop;
    logic            w_frame_start;
    logic            w_par_pend;
    logic            w_unused_ctrl;

    uart_rx_sync u_sync (
        .clk     (clk),
        .reset   (reset),
        .rx      (rx),
        .rx_s    (w_rx_s),
        .rx_fall (w_rx_fall)
    );

    assign w_nbits       = decode_num_bits(r_ctrl.num_bits);
    assign w_start_tick  = baud_x16 && (r_tcnt == C_HALF);
    assign w_bit_tick    = baud_x16 && (r_tcnt == C_FULL);
    assign w_frame_start = (r_state == IDLE) && w_rx_fall;
    assign w_unused_ctrl = ^{r_ctrl.stop2, r_ctrl.parity_odd};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= WAIT_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_drop = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rx_fall) w_next = START;
            end
            START: begin
                if (w_start_tick) w_next = w_rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (w_bit_tick && (r_bcnt == w_nbits - 4'd1)) begin
                    w_next = r_ctrl.parity_en ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (w_bit_tick) w_next = STOP;
            end
            STOP: begin
                if (w_bit_tick) begin
                    // An accept in this same cycle frees the holding slot.
                    if (r_vld && !rdy) begin
                        w_drop = 1'b1;
                    end else begin
                        w_load = 1'b1;
                    end
                    w_next = w_rx_s ? IDLE : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (w_rx_s) w_next = IDLE;
            end
            default: w_next = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tcnt  <= '0;
            r_bcnt  <= '0;
            r_shift <= '0;
            r_ctrl  <= '0;
            r_data  <= '0;
            r_vld   <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            if (w_next != r_state) begin
                r_tcnt <= '0;
            end else if (baud_x16) begin
                r_tcnt <= r_tcnt + 1'b1;
            end

            if (w_frame_start) begin
                r_ctrl  <= control;
                r_shift <= '0;
                r_bcnt  <= '0;
            end else if ((r_state == DATA) && w_bit_tick) begin
                r_shift[r_bcnt] <= w_rx_s;
                r_bcnt          <= r_bcnt + 4'd1;
            end

            if (w_load) begin
                r_data <= r_shift;
                r_perr <= w_par_pend;
                r_ferr <= ~w_rx_s;
                r_vld  <= 1'b1;
            end else if (r_vld && rdy) begin
                r_vld <= 1'b0;
            end

            r_ovr <= w_drop;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_par_pend;

    always_ff @(posedge clk) begin
        if (reset || w_frame_start) begin
            r_par_pend <= 1'b0;
        end else if ((r_state == PARITY) && w_bit_tick) begin
            r_par_pend <= w_rx_s ^ (^r_shift) ^ r_ctrl.parity_odd;
        end
    end

    assign w_par_pend = r_par_pend;
`else
    assign w_par_pend = 1'b0;
`endif

    assign data       = r_data;
    assign vld        = r_vld;
    assign parity_err = r_perr;
    assign frame_err  = r_ferr;
    assign overrun    = r_ovr;
    assign busy       = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_control
// Description : Self-checking bench for uart_rx_control with a scoreboard of
//               expected words popped on each accepted handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_control;
    import uart_pkg::*;

    localparam int C_DIV = 4;
    localparam int C_BIT = 16 * C_DIV;
`ifdef UART_RX_PARITY_EN
    localparam logic C_PAR_CHK = 1'b1;
`else
    localparam logic C_PAR_CHK = 1'b0;
`endif

    typedef struct packed {
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       baud_x16;
    control_t   control;
    logic       rx;
    logic [8:0] data;
    logic       vld;
    logic       rdy;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int   checks   = 0;
    int   failures = 0;
    int   ovr_cnt  = 0;
    exp_t q[$];

    uart_rx_control #(.OVERSAMPLE(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .baud_x16   (baud_x16),
        .control    (control),
        .rx         (rx),
        .data       (data),
        .vld        (vld),
        .rdy        (rdy),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        baud_x16 = 1'b0;
        forever begin
            repeat (C_DIV - 1) @(posedge clk);
            #1 baud_x16 = 1'b1;
            @(posedge clk);
            #1 baud_x16 = 1'b0;
        end
    end

    // Scoreboard: every accepted word must match the head of the queue.
    always @(negedge clk) begin
        if (!reset && overrun) ovr_cnt++;
        if (!reset && vld && rdy) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_word data=%h perr=%b ferr=%b (no word expected)",
                         data, parity_err, frame_err);
            end else begin
                exp_t e;
                e = q.pop_front();
                if ({data, parity_err, frame_err} !== e) begin
                    failures++;
                    $display("FAIL word data=%h perr=%b ferr=%b expected data=%h perr=%b ferr=%b",
                             data, parity_err, frame_err, e.d, e.pe, e.fe);
                end
            end
        end
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (C_BIT) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [8:0] d, input logic [2:0] nb_code,
                              input logic pen, input logic podd, input logic bad_par,
                              input logic stop_bit, input logic push);
        int         nb;
        logic [8:0] m;
        exp_t       e;
        nb = (nb_code <= 3'd4) ? int'(nb_code) + 5 : 8;
        m  = 9'h000;
        for (int i = 0; i < nb; i++) m[i] = d[i];
        if (push) begin
            e.d  = m;
            e.pe = pen & bad_par & C_PAR_CHK;
            e.fe = ~stop_bit;
            q.push_back(e);
        end
        control = '{num_bits: nb_code, parity_en: pen, parity_odd: podd, stop2: 1'b0};
        drive_bit(1'b0);
        for (int i = 0; i < nb; i++) drive_bit(m[i]);
        if (pen) drive_bit((^m) ^ podd ^ bad_par);
        drive_bit(stop_bit);
        if (stop_bit) drive_bit(1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({data, vld, parity_err, frame_err, overrun} !== 13'h0) begin
            failures++;
            $display("FAIL reset_outputs data=%h vld=%b perr=%b ferr=%b ovr=%b expected all 0",
                     data, vld, parity_err, frame_err, overrun);
        end
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_busy got %b expected 1", busy);
        end
        align();
        reset = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset busy=%b expected 0", busy);
        end
    endtask

    task automatic test_8n1();
        align();
        rdy = 1'b1;
        send_frame(9'h0A5, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        send_frame(9'h013, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        send_frame(9'h0C3, 3'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (q.size() != 0 || vld !== 1'b0) begin
            failures++;
            $display("FAIL 8n1_drain pending=%0d vld=%b expected 0 and 0", q.size(), vld);
        end
    endtask

    task automatic test_parity();
        align();
        rdy = 1'b1;
        send_frame(9'h1FF, 3'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        send_frame(9'h035, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        send_frame(9'h0F0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL parity_drain pending=%0d expected 0", q.size());
        end
    endtask

    task automatic test_glitch();
        align();
        rdy = 1'b1;
        rx  = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL glitch_start busy=%b expected 1", busy);
        end
        align();
        repeat (5 * C_DIV - 6) @(posedge clk);
        #1 rx = 1'b1;
        repeat (C_DIV) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL glitch_wait_sample busy=%b expected 1", busy);
        end
        repeat (2 * C_DIV + 8) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || vld !== 1'b0) begin
            failures++;
            $display("FAIL glitch_reject busy=%b vld=%b expected 0 and 0", busy, vld);
        end
    endtask

    task automatic test_break();
        align();
        rdy = 1'b1;
        send_frame(9'h000, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3 * C_BIT) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || vld !== 1'b0 || q.size() != 0) begin
            failures++;
            $display("FAIL break_hold busy=%b vld=%b pending=%0d expected 1 0 0", busy, vld, q.size());
        end
        align();
        drive_bit(1'b1);
        drive_bit(1'b1);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL break_release busy=%b expected 0", busy);
        end
        align();
        send_frame(9'h055, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_overrun();
        int ovr0;
        align();
        ovr0 = ovr_cnt;
        rdy  = 1'b0;
        send_frame(9'h011, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        send_frame(9'h022, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (vld !== 1'b1 || data !== 9'h011) begin
            failures++;
            $display("FAIL overrun_hold vld=%b data=%h expected 1 and 011", vld, data);
        end
        checks++;
        if (ovr_cnt - ovr0 != 1) begin
            failures++;
            $display("FAIL overrun_pulses got %0d expected 1", ovr_cnt - ovr0);
        end
        align();
        rdy = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (vld !== 1'b0 || q.size() != 0) begin
            failures++;
            $display("FAIL overrun_accept vld=%b pending=%0d expected 0 and 0", vld, q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] w;
        align();
        rdy = 1'b0;
        send_frame(9'h05A, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (vld !== 1'b1 || data !== 9'h05A) begin
            failures++;
            $display("FAIL held_before_reset vld=%b data=%h expected 1 and 05a", vld, data);
        end
        align();
        w = 8'h3C;
        control = '{num_bits: 3'd3, parity_en: 1'b0, parity_odd: 1'b0, stop2: 1'b0};
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(w[i]);
        rx = w[3];
        repeat (C_BIT / 2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if (vld !== 1'b0 || data !== 9'h000 || busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_frame vld=%b data=%h busy=%b expected 0 000 1", vld, data, busy);
        end
        align();
        rx = 1'b1;
        drive_bit(1'b1);
        drive_bit(1'b1);
        rdy = 1'b1;
        send_frame(9'h03C, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (q.size() != 0 || vld !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_drain pending=%0d vld=%b expected 0 and 0", q.size(), vld);
        end
    endtask

    initial begin
        reset   = 1'b1;
        rx      = 1'b1;
        rdy     = 1'b1;
        control = '0;
        test_reset();
        test_8n1();
        test_parity();
        test_glitch();
        test_break();
        test_overrun();
        test_reset_mid();
        checks++;
        if (ovr_cnt != 1) begin
            failures++;
            $display("FAIL total_overruns got %0d expected 1", ovr_cnt);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
